// File: rtl/multdiv_ctrl_pkg.sv
// Pipeline constants and state encoding shared by the multdiv sequencer and the stall unit.
package multdiv_ctrl_pkg;

  localparam logic [4:0]  OPC_RTYPE    = 5'b00000;
  localparam logic [4:0]  ALU_MULT     = 5'b00110;
  localparam logic [4:0]  ALU_DIV      = 5'b00111;

  localparam logic [4:0]  REG_RSTATUS  = 5'd30;
  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE
  } md_state_e;

endpackage

// File: rtl/multdiv_ctrl_md_decode.sv
// Combinational mult/div decode of an instruction word; the stall unit uses the same block.
module md_decode
  import multdiv_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_mult,
  output logic        is_div
);

  logic rtype;
  logic unused_ir;

  assign rtype     = (ir[31:27] == OPC_RTYPE);
  assign is_mult   = rtype && (ir[6:2] == ALU_MULT);
  assign is_div    = rtype && (ir[6:2] == ALU_DIV);
  assign unused_ir = ^{ir[26:7], ir[1:0]};

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences one mult/div from DX through the iterative core and returns a single-cycle writeback.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir_in,
  input  logic [31:0] dx_operand_a,
  input  logic [31:0] dx_operand_b,
  input  logic [31:0] core_result,
  input  logic        core_exception,
  input  logic        core_result_rdy,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] core_operand_a,
  output logic [31:0] core_operand_b,
  output logic        multdiv_is_running,
  output logic        multdiv_result_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_error
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             is_div_q;
  logic             dx_is_mult, dx_is_div;
  logic [4:0]       fin_rd;
  logic [31:0]      fin_data;

  md_decode u_dec (
    .ir      (dx_ir_in),
    .is_mult (dx_is_mult),
    .is_div  (dx_is_div)
  );

  // Exceptions redirect the writeback to the status register with a cause code.
  always_comb begin
    fin_rd   = rd_q;
    fin_data = core_result;
    if (core_exception) begin
      fin_rd   = REG_RSTATUS;
      fin_data = is_div_q ? RSTATUS_DIV : RSTATUS_MULT;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      rd_q                 <= '0;
      is_div_q             <= 1'b0;
      core_operand_a       <= '0;
      core_operand_b       <= '0;
      ctrl_mult            <= 1'b0;
      ctrl_div             <= 1'b0;
      multdiv_is_running   <= 1'b0;
      multdiv_result_ready <= 1'b0;
      wb_we                <= 1'b0;
      wb_rd                <= '0;
      wb_data              <= '0;
      timeout_error        <= 1'b0;
    end else begin
      ctrl_mult            <= 1'b0;
      ctrl_div             <= 1'b0;
      multdiv_result_ready <= 1'b0;
      wb_we                <= 1'b0;
      wb_rd                <= '0;
      wb_data              <= '0;
      case (state)
        ST_IDLE: begin
          if (dx_is_mult || dx_is_div) begin
            rd_q               <= dx_ir_in[26:22];
            is_div_q           <= dx_is_div;
            core_operand_a     <= dx_operand_a;
            core_operand_b     <= dx_operand_b;
            ctrl_mult          <= dx_is_mult;
            ctrl_div           <= dx_is_div;
            multdiv_is_running <= 1'b1;
            state              <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          // A result arriving on the last allowed cycle still beats the timeout.
          if (core_result_rdy) begin
            multdiv_is_running   <= 1'b0;
            multdiv_result_ready <= 1'b1;
            wb_rd                <= fin_rd;
            wb_data              <= fin_data;
            wb_we                <= (fin_rd != 5'd0);
            state                <= ST_DONE;
          end else if (cnt == CNT_W'(MAX_CYCLES - 1)) begin
            multdiv_is_running <= 1'b0;
            timeout_error      <= 1'b1;
            state              <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed scoreboard bench for multdiv_ctrl: expected writebacks are queued at issue, a monitor checks them.
module tb_multdiv_ctrl;
  import multdiv_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir_in, dx_operand_a, dx_operand_b, core_result;
  logic        core_exception, core_result_rdy;
  logic        ctrl_mult, ctrl_div, multdiv_is_running, multdiv_result_ready;
  logic [31:0] core_operand_a, core_operand_b, wb_data;
  logic        wb_we, timeout_error;
  logic [4:0]  wb_rd;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_t;

  wb_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_mult = 0;
  int   n_div = 0;
  logic prev_rr = 1'b0;

  multdiv_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clock                (clock),
    .reset                (reset),
    .dx_ir_in             (dx_ir_in),
    .dx_operand_a         (dx_operand_a),
    .dx_operand_b         (dx_operand_b),
    .core_result          (core_result),
    .core_exception       (core_exception),
    .core_result_rdy      (core_result_rdy),
    .ctrl_mult            (ctrl_mult),
    .ctrl_div             (ctrl_div),
    .core_operand_a       (core_operand_a),
    .core_operand_b       (core_operand_b),
    .multdiv_is_running   (multdiv_is_running),
    .multdiv_result_ready (multdiv_result_ready),
    .wb_we                (wb_we),
    .wb_rd                (wb_rd),
    .wb_data              (wb_data),
    .timeout_error        (timeout_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] op);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, op, 2'b00};
  endfunction

  // Monitor: every writeback must match the head of the expectation queue.
  always @(negedge clock) begin
    if (ctrl_mult) n_mult++;
    if (ctrl_div)  n_div++;
    if (multdiv_result_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: got rd=%0d data=%h we=%b expected no writeback", wb_rd, wb_data, wb_we);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_we", 32'(wb_we), 32'(e.we));
      end
      chk("rr_single_cycle", 32'(prev_rr), 32'd0);
    end
    prev_rr = multdiv_result_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Present an instruction for one cycle; returns in the START cycle with the start pulse checked.
  task automatic launch(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    logic d;
    d = (ir[6:2] == ALU_DIV);
    dx_ir_in = ir; dx_operand_a = a; dx_operand_b = b;
    step();
    dx_ir_in = '0; dx_operand_a = '0; dx_operand_b = '0;
    chk("start_mult", 32'(ctrl_mult), 32'(!d));
    chk("start_div", 32'(ctrl_div), 32'(d));
    chk("start_running", 32'(multdiv_is_running), 32'd1);
    chk("op_a", core_operand_a, a);
    chk("op_b", core_operand_b, b);
  endtask

  // Core answers 'delay' cycles after the start pulse.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                        input int delay, input logic [31:0] res, input logic exc);
    launch(ir, a, b);
    for (int k = 2; k <= 1 + delay; k++) begin
      step();
      chk("run_running", 32'(multdiv_is_running), 32'd1);
      chk("run_no_pulse", 32'(ctrl_mult | ctrl_div), 32'd0);
      if (k == 1 + delay) begin
        core_result = res; core_exception = exc; core_result_rdy = 1'b1;
      end
    end
    step();
    core_result_rdy = 1'b0; core_exception = 1'b0; core_result = '0;
    chk("done_running", 32'(multdiv_is_running), 32'd0);
    chk("done_rr", 32'(multdiv_result_ready), 32'd1);
    step();
    chk("after_done_rr", 32'(multdiv_result_ready), 32'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b0;
    dx_ir_in = '0; dx_operand_a = '0; dx_operand_b = '0;
    core_result = '0; core_exception = 1'b0; core_result_rdy = 1'b0;
    step(3);
    chk("rst_running", 32'(multdiv_is_running), 32'd0);
    chk("rst_rr", 32'(multdiv_result_ready), 32'd0);
    chk("rst_ctrl", 32'({ctrl_mult, ctrl_div}), 32'd0);
    chk("rst_timeout", 32'(timeout_error), 32'd0);
    chk("rst_op_a", core_operand_a, 32'd0);
    reset = 1'b1;
    step();

    // mult r3 = 6*7, core answers 17 cycles after the start pulse
    exp_q.push_back(wb_t'{5'd3, 32'd42, 1'b1});
    run_op(mk(5'd3, ALU_MULT), 32'd6, 32'd7, 17, 32'd42, 1'b0);

    // div r5 = 100/0 with exception -> status register, cause 5
    exp_q.push_back(wb_t'{5'd30, 32'd5, 1'b1});
    run_op(mk(5'd5, ALU_DIV), 32'd100, 32'd0, 5, 32'hFFFF_FFFF, 1'b1);

    // mult with exception -> cause 4
    exp_q.push_back(wb_t'{5'd30, 32'd4, 1'b1});
    run_op(mk(5'd9, ALU_MULT), 32'h7FFF_FFFF, 32'd2, 2, 32'hFFFF_FFFE, 1'b1);

    // mult into r0: result_ready without write enable
    exp_q.push_back(wb_t'{5'd0, 32'h12, 1'b0});
    run_op(mk(5'd0, ALU_MULT), 32'd3, 32'd6, 3, 32'h12, 1'b0);

    // stray core strobe in IDLE is ignored
    core_result = 32'hBAD; core_result_rdy = 1'b1;
    step();
    core_result_rdy = 1'b0;
    step(2);
    chk("idle_rdy_running", 32'(multdiv_is_running), 32'd0);

    // core never answers: 40 RUN cycles then timeout
    launch(mk(5'd4, ALU_MULT), 32'd1, 32'd1);
    for (int k = 2; k <= 41; k++) begin
      step();
      chk("to_running", 32'(multdiv_is_running), 32'd1);
      chk("to_not_yet", 32'(timeout_error), 32'd0);
    end
    step();
    chk("to_set", 32'(timeout_error), 32'd1);
    chk("to_idle_running", 32'(multdiv_is_running), 32'd0);
    step();

    // next op launches normally; result on the 40th RUN cycle beats the timeout
    exp_q.push_back(wb_t'{5'd7, 32'd9, 1'b1});
    run_op(mk(5'd7, ALU_MULT), 32'd3, 32'd3, 40, 32'd9, 1'b0);
    chk("to_sticky", 32'(timeout_error), 32'd1);

    // reset mid-RUN, then a late core strobe
    launch(mk(5'd6, ALU_MULT), 32'd8, 32'd8);
    step(4);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mrst_running", 32'(multdiv_is_running), 32'd0);
    chk("mrst_timeout", 32'(timeout_error), 32'd0);
    chk("mrst_op_a", core_operand_a, 32'd0);
    chk("mrst_op_b", core_operand_b, 32'd0);
    chk("mrst_wb", {wb_data[31:6], wb_we, wb_rd}, 32'd0);
    core_result = 32'd64; core_result_rdy = 1'b1;
    step();
    core_result_rdy = 1'b0;
    step(3);
    chk("mrst_late_running", 32'(multdiv_is_running), 32'd0);

    // back-to-back: div shown in DX during DONE (refused) and again in IDLE (accepted)
    exp_q.push_back(wb_t'{5'd3, 32'd20, 1'b1});
    exp_q.push_back(wb_t'{5'd5, 32'd2, 1'b1});
    d0 = n_div;
    launch(mk(5'd3, ALU_MULT), 32'd4, 32'd5);
    step(2);
    core_result = 32'd20; core_result_rdy = 1'b1;
    step();
    core_result_rdy = 1'b0;
    chk("b2b_done", 32'(multdiv_result_ready), 32'd1);
    dx_ir_in = mk(5'd5, ALU_DIV); dx_operand_a = 32'd10; dx_operand_b = 32'd5;
    step();
    chk("b2b_refused", 32'(ctrl_div), 32'd0);
    chk("b2b_refused_run", 32'(multdiv_is_running), 32'd0);
    launch(mk(5'd5, ALU_DIV), 32'd10, 32'd5);
    step(2);
    core_result = 32'd2; core_result_rdy = 1'b1;
    step();
    core_result_rdy = 1'b0;
    step(3);
    chk("b2b_div_once", 32'(n_div - d0), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
